// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampling UART receiver.
//   rx_state_e  : receiver FSM states
//   OS_RATE     : samples per bit; SCNT_W is the sample-counter width
//   VOTE_S0..S2 : sample indices used by the 2-of-3 majority vote
//   LAST_SAMPLE : final sample index of a bit period
//   majority3() : 2-of-3 majority helper
package uart_pkg;

    localparam int OS_RATE = 16;
    localparam int SCNT_W  = $clog2(OS_RATE);

    localparam logic [SCNT_W-1:0] VOTE_S0     = SCNT_W'(7);
    localparam logic [SCNT_W-1:0] VOTE_S1     = SCNT_W'(8);
    localparam logic [SCNT_W-1:0] VOTE_S2     = SCNT_W'(9);
    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(15);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Received-word stream between the UART receiver and its consumer.
//   rx_data    : received word, right-justified
//   rx_valid   : holding register full
//   rx_ready   : consumer accepts the word on rx_valid & rx_ready
//   parity_err : parity mismatch for rx_data, qualified by rx_valid
//   frame_err  : stop bit sampled 0 for rx_data, qualified by rx_valid
// master = receiver side, slave = consumer side.
interface uart_rx_os16_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// rx synchroniser and 3-sample majority voter.
//   clk, reset    : system clock, asynchronous active-high reset
//   baud_x16_tick : 16x baud tick; samples are only captured on ticks
//   rx            : asynchronous serial input (idles high)
//   s_idx         : sample index of the current tick within the bit
//   rx_sync       : synchronised rx
//   vote          : 2-of-3 majority of rx_sync at samples 7, 8, 9;
//                   valid on the tick whose s_idx is 9
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_x16_tick,
    input  logic              rx,
    input  logic [SCNT_W-1:0] s_idx,
    output logic              rx_sync,
    output logic              vote
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   samp0;
    logic                   samp1;

    // Synchroniser resets to the idle (high) line level so no false start
    // is seen coming out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            samp0  <= 1'b1;
            samp1  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage take the value
            // its predecessor held before this edge, forming a true shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            if (baud_x16_tick && s_idx == VOTE_S0) samp0 <= sync_q[SYNC_STAGES-1];
            if (baud_x16_tick && s_idx == VOTE_S1) samp1 <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];

    // The third sample is the live synced value on the s_idx=9 tick.
    assign vote = majority3(samp0, samp1, rx_sync);

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver, 16x oversampling, with one-entry valid/ready holding register.
//   clk, reset    : system clock, asynchronous active-high reset
//   baud_x16_tick : one-clk pulse at 16x baud; the block advances only on it
//   rx            : asynchronous serial input (idles high)
//   rx_if         : received-word stream (rx_data/rx_valid/rx_ready and
//                   per-word parity_err/frame_err)
//   overrun_err   : one-clk pulse, frame completed while holding reg full
//   break_det     : one-clk pulse on break detection
//   busy          : FSM not in IDLE
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter bit PARITY_EN   = 1'b0,
    parameter bit PARITY_ODD  = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  baud_x16_tick,
    input  logic                  rx,
    uart_rx_os16_if.master        rx_if,
    output logic                  overrun_err,
    output logic                  break_det,
    output logic                  busy
);

    rx_state_e              state;
    logic [SCNT_W-1:0]      s_cnt;
    logic [SCNT_W-1:0]      s_idx;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   perr_q;
    logic                   par_vote_q;
    logic [7:0]             data_q;
    logic                   valid_q;
    logic                   perr_out;
    logic                   ferr_out;
    logic                   rx_sync;
    logic                   vote;
    logic                   is_break;

    uart_rx_sampler #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk          (clk),
        .reset        (reset),
        .baud_x16_tick(baud_x16_tick),
        .rx           (rx),
        .s_idx        (s_idx),
        .rx_sync      (rx_sync),
        .vote         (vote)
    );

    // Sample index of the current tick. The start-detect tick is sample 0 and
    // s_cnt holds the index of the last tick, so each later tick is s_cnt + 1
    // (wrapping 15 -> 0 at bit boundaries).
    assign s_idx = (state == IDLE) ? '0 : s_cnt + 1'b1;

    // Break: all-zero data, zero parity vote (when present) and zero stop vote.
    assign is_break = (shreg == '0) && !(PARITY_EN && par_vote_q) && !vote;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            s_cnt       <= '0;
            bit_cnt     <= '0;
            // NOTE: the datapath registers are reset as well, because rx_data
            // and the flags must read 0 after reset, not stale frame contents.
            shreg       <= '0;
            perr_q      <= 1'b0;
            par_vote_q  <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_out    <= 1'b0;
            ferr_out    <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            break_det   <= 1'b0;

            // A read empties the register unless a completion below reloads it.
            if (valid_q && rx_if.rx_ready) valid_q <= 1'b0;

            if (baud_x16_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_sync) begin
                            state <= START;
                            s_cnt <= '0;
                        end
                    end

                    START: begin
                        s_cnt <= s_idx;
                        if (s_idx == VOTE_S2 && vote) begin
                            state <= IDLE;
                            s_cnt <= '0;
                        end else if (s_idx == LAST_SAMPLE) begin
                            state <= DATA;
                        end
                    end

                    DATA: begin
                        s_cnt <= s_idx;
                        if (s_idx == VOTE_S2) shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (s_idx == LAST_SAMPLE) begin
                            if (bit_cnt == 3'(DATA_BITS - 1)) begin
                                bit_cnt <= '0;
                                state   <= PARITY_EN ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    PARITY: begin
                        s_cnt <= s_idx;
                        if (s_idx == VOTE_S2) begin
                            perr_q     <= vote ^ (^shreg) ^ PARITY_ODD;
                            par_vote_q <= vote;
                        end
                        if (s_idx == LAST_SAMPLE) state <= STOP;
                    end

                    STOP: begin
                        s_cnt <= s_idx;
                        if (s_idx == VOTE_S2) begin
                            // Leave at mid-stop so the next start edge can be
                            // caught half a bit early.
                            s_cnt     <= '0;
                            state     <= is_break ? BRK_WAIT : IDLE;
                            break_det <= is_break;
                            if (!valid_q || rx_if.rx_ready) begin
                                data_q   <= 8'(shreg);
                                perr_out <= PARITY_EN && perr_q;
                                ferr_out <= !vote;
                                valid_q  <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end
                    end

                    BRK_WAIT: begin
                        if (rx_sync) state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                        s_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.parity_err = perr_out;
    assign rx_if.frame_err  = ferr_out;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed testbench for uart_rx_os16.
// dut_a: 8N1; dut_b: 8E1. Tick every 4 clks, so one bit = 64 clks.
// Frames start on a clk phase chosen so the start-detect tick lands 3 clks
// after the rx falling edge; sample k of frame bit j then falls on the
// (3 + 64*j + 4*k)-th rising edge after the start edge.
module tb_uart_rx_os16;

    logic clk = 1'b0;
    logic reset;
    logic tick;
    logic rx_a, rx_b;
    logic ovr_a, brk_a, busy_a;
    logic ovr_b, brk_b, busy_b;

    int checks = 0;
    int errors = 0;
    int phase  = 0;
    int ovr_cnt_a = 0, brk_cnt_a = 0, ovr_cnt_b = 0, brk_cnt_b = 0;
    int snap_ovr, snap_brk;

    uart_rx_os16_if ifa ();
    uart_rx_os16_if ifb ();

    always #5 clk = ~clk;

    uart_rx_os16 #(
        .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .SYNC_STAGES(2)
    ) dut_a (
        .clk          (clk),
        .reset        (reset),
        .baud_x16_tick(tick),
        .rx           (rx_a),
        .rx_if        (ifa),
        .overrun_err  (ovr_a),
        .break_det    (brk_a),
        .busy         (busy_a)
    );

    uart_rx_os16 #(
        .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .SYNC_STAGES(2)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .baud_x16_tick(tick),
        .rx           (rx_b),
        .rx_if        (ifb),
        .overrun_err  (ovr_b),
        .break_det    (brk_b),
        .busy         (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, drive the tick and count output pulses
    // (each rising edge's registered value is seen exactly once here).
    task automatic step();
        @(negedge clk);
        phase = (phase + 1) % 4;
        tick  = (phase == 0);
        if (ovr_a) ovr_cnt_a++;
        if (brk_a) brk_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
        if (brk_b) brk_cnt_b++;
    endtask

    // Send nbits of frame (bit 0 = start) on dut_a (sel=0) or dut_b (sel=1).
    // glitch_bit >= 0 flips that frame bit for one clk so only sample 8 sees it.
    // ready_at >= 0 pulses rx_ready for one clk before rising edge ready_at+1.
    task automatic send_raw(input bit sel, input logic [11:0] frame, input int nbits,
                            input int glitch_bit, input int ready_at);
        logic b;
        while (phase != 2) step();
        for (int i = 0; i < nbits * 64; i++) begin
            b = frame[i / 64];
            if (glitch_bit >= 0 && i == glitch_bit * 64 + 32) b = ~b;
            if (sel) rx_b = b; else rx_a = b;
            if (ready_at >= 0) begin
                if (sel) ifb.rx_ready = (i == ready_at);
                else     ifa.rx_ready = (i == ready_at);
            end
            step();
        end
    endtask

    task automatic wait_valid(input bit sel, input string tag);
        for (int i = 0; i < 300 && !(sel ? ifb.rx_valid : ifa.rx_valid); i++) step();
        check(tag, sel ? ifb.rx_valid : ifa.rx_valid, 1);
    endtask

    task automatic read_word(input bit sel, input string tag);
        if (sel) ifb.rx_ready = 1'b1; else ifa.rx_ready = 1'b1;
        step();
        if (sel) ifb.rx_ready = 1'b0; else ifa.rx_ready = 1'b0;
        check(tag, sel ? ifb.rx_valid : ifa.rx_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        ifa.rx_ready = 1'b0;
        ifb.rx_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_valid", ifa.rx_valid, 0);
        check("rst_data", ifa.rx_data, 8'h00);
        check("rst_busy", busy_a, 0);
        check("rst_flags", {ifa.parity_err, ifa.frame_err, ovr_a, brk_a}, 4'b0000);
        reset = 1'b0;
        repeat (8) step();

        // 8N1 0xA5
        send_raw(0, {3'b111, 8'hA5, 1'b0}, 10, -1, -1);
        wait_valid(0, "a5_valid");
        check("a5_data", ifa.rx_data, 8'hA5);
        check("a5_perr", ifa.parity_err, 0);
        check("a5_ferr", ifa.frame_err, 0);
        read_word(0, "a5_read");

        // False start: low for 5 ticks, then high
        while (phase != 2) step();
        rx_a = 1'b0;
        repeat (20) step();
        check("fs_busy_hi", busy_a, 1);
        rx_a = 1'b1;
        repeat (80) step();
        check("fs_busy_lo", busy_a, 0);
        check("fs_no_valid", ifa.rx_valid, 0);
        send_raw(0, {3'b111, 8'h3C, 1'b0}, 10, -1, -1);
        wait_valid(0, "3c_valid");
        check("3c_data", ifa.rx_data, 8'h3C);
        read_word(0, "3c_read");

        // Even parity: 0x31 has three ones, correct parity bit is 1
        send_raw(1, {2'b11, 1'b0, 8'h31, 1'b0}, 11, -1, -1);
        wait_valid(1, "p_bad_valid");
        check("p_bad_data", ifb.rx_data, 8'h31);
        check("p_bad_perr", ifb.parity_err, 1);
        check("p_bad_ferr", ifb.frame_err, 0);
        read_word(1, "p_bad_read");
        send_raw(1, {2'b11, 1'b1, 8'h31, 1'b0}, 11, -1, -1);
        wait_valid(1, "p_ok_valid");
        check("p_ok_data", ifb.rx_data, 8'h31);
        check("p_ok_perr", ifb.parity_err, 0);
        read_word(1, "p_ok_read");

        // Stop bit 0 with non-zero data: frame error, not a break
        send_raw(1, {2'b10, 1'b1, 8'h31, 1'b0}, 11, -1, -1);
        rx_b = 1'b1;
        wait_valid(1, "fe_valid");
        check("fe_ferr", ifb.frame_err, 1);
        check("fe_perr", ifb.parity_err, 0);
        repeat (100) step();
        check("fe_busy", busy_b, 0);
        check("fe_no_brk", brk_cnt_b, 0);
        check("fe_no_ovr", ovr_cnt_b, 0);
        read_word(1, "fe_read");

        // Break: rx low for three frame times
        snap_ovr = ovr_cnt_a;
        snap_brk = brk_cnt_a;
        while (phase != 2) step();
        rx_a = 1'b0;
        repeat (1920) step();
        check("brk_busy", busy_a, 1);
        rx_a = 1'b1;
        repeat (100) step();
        check("brk_pulses", brk_cnt_a - snap_brk, 1);
        check("brk_no_ovr", ovr_cnt_a - snap_ovr, 0);
        check("brk_valid", ifa.rx_valid, 1);
        check("brk_data", ifa.rx_data, 8'h00);
        check("brk_ferr", ifa.frame_err, 1);
        check("brk_idle", busy_a, 0);
        read_word(0, "brk_read");
        send_raw(0, {3'b111, 8'h55, 1'b0}, 10, -1, -1);
        wait_valid(0, "55_valid");
        check("55_data", ifa.rx_data, 8'h55);
        check("55_ferr", ifa.frame_err, 0);
        read_word(0, "55_read");

        // Overrun: back-to-back frames with no read
        snap_ovr = ovr_cnt_a;
        send_raw(0, {3'b111, 8'h11, 1'b0}, 10, -1, -1);
        send_raw(0, {3'b111, 8'h22, 1'b0}, 10, -1, -1);
        check("ovr_pulse", ovr_cnt_a - snap_ovr, 1);
        check("ovr_data", ifa.rx_data, 8'h11);
        check("ovr_valid", ifa.rx_valid, 1);
        read_word(0, "ovr_read");

        // Read coincides with completion of the second frame (rising edge 615)
        snap_ovr = ovr_cnt_a;
        send_raw(0, {3'b111, 8'h11, 1'b0}, 10, -1, -1);
        send_raw(0, {3'b111, 8'h22, 1'b0}, 10, -1, 614);
        check("rdc_no_ovr", ovr_cnt_a - snap_ovr, 0);
        check("rdc_data", ifa.rx_data, 8'h22);
        check("rdc_valid", ifa.rx_valid, 1);

        // Reset during data bit 4 with a word still held
        send_raw(0, {3'b111, 8'hC3, 1'b0}, 5, -1, -1);
        rx_a = 1'b0;
        repeat (20) step();
        reset = 1'b1;
        step();
        step();
        check("mrst_valid", ifa.rx_valid, 0);
        check("mrst_data", ifa.rx_data, 8'h00);
        check("mrst_busy", busy_a, 0);
        check("mrst_flags", {ifa.parity_err, ifa.frame_err, ovr_a, brk_a}, 4'b0000);
        rx_a  = 1'b1;
        reset = 1'b0;
        repeat (200) step();
        check("mrst_idle", busy_a, 0);
        check("mrst_no_valid", ifa.rx_valid, 0);

        // 0xF0 with a one-clk glitch at sample 8 of data bit 5 (frame bit 6)
        send_raw(0, {3'b111, 8'hF0, 1'b0}, 10, 6, -1);
        wait_valid(0, "f0_valid");
        check("f0_data", ifa.rx_data, 8'hF0);
        check("f0_ferr", ifa.frame_err, 0);
        read_word(0, "f0_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
